// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================
// uart_pkg : shared UART types, constants and baud helper
// Rev 1.0
// ============================================================
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    // Clocks per oversample tick, floored, never below one.
    function automatic int calc_tick_div(input int clk_freq, input int baud_rate);
        int d;
        d = clk_freq / (baud_rate * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================
// uart_baud_tick : free-running oversample tick divider
// Rev 1.0
// ============================================================
module uart_baud_tick #(
    parameter int TICK_DIV = 27
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int             CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap;

    always_comb begin
        wrap  = (cnt_q == LAST);
        cnt_d = wrap ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = wrap;

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================
// uart_receiver : 8N1 receiver, 16x oversampling, one-byte buffer
// Rev 1.0
// ============================================================
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int TICK_DIV  = calc_tick_div(CLK_FREQ, BAUD_RATE)
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Rxd,
    output logic [DATA_BITS-1:0] RxData,
    output logic                 RxValid,
    input  logic                 RxAck,
    output logic                 FrameError,
    output logic                 Overrun,
    output logic                 Busy
);

    logic                 rx_meta_q;
    logic                 rx_s_q;
    logic                 tick;
    rx_state_t            state_q;
    logic [3:0]           smp_cnt_q;
    logic [2:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 accept_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= Rxd;
            rx_s_q    <= rx_meta_q;
        end
    end

    uart_baud_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_baud_tick (
        .clk_i  (Clock),
        .rst_i  (Reset),
        .tick_o (tick)
    );

    // The sample counter is zeroed at the start-bit midpoint, so every
    // later sample lands when it has counted a full 16 ticks.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            smp_cnt_q   <= 4'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= '0;
            accept_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            accept_q    <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q   <= START;
                        smp_cnt_q <= 4'd0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (smp_cnt_q == 4'd7) begin
                            smp_cnt_q <= 4'd0;
                            if (!rx_s_q) begin
                                state_q   <= DATA;
                                bit_idx_q <= 3'd0;
                            end else begin
                                state_q   <= IDLE;
                            end
                        end else begin
                            smp_cnt_q <= smp_cnt_q + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        smp_cnt_q <= smp_cnt_q + 4'd1;
                        if (smp_cnt_q == 4'd15) begin
                            shift_q   <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                            bit_idx_q <= bit_idx_q + 3'd1;
                            if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                                state_q <= STOP;
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        smp_cnt_q <= smp_cnt_q + 4'd1;
                        if (smp_cnt_q == 4'd15) begin
                            if (rx_s_q) begin
                                accept_q    <= 1'b1;
                                state_q     <= IDLE;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= WAIT_HIGH;
                            end
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // A simultaneous ack frees the buffer on the very edge the new byte lands.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (accept_q) begin
                if (!rx_valid_q || RxAck) begin
                    rx_data_q  <= shift_q;
                    rx_valid_q <= 1'b1;
                end else begin
                    overrun_q  <= 1'b1;
                end
            end else if (RxAck) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign RxData     = rx_data_q;
    assign RxValid    = rx_valid_q;
    assign FrameError = frame_err_q;
    assign Overrun    = overrun_q;
    assign Busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================
// tb_uart_receiver : directed self-checking bench for uart_receiver
// Rev 1.0
// ============================================================
module tb_uart_receiver;

    localparam int BIT = 432;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Rxd   = 1'b1;
    logic       RxAck = 1'b0;
    logic [7:0] RxData;
    logic       RxValid;
    logic       FrameError;
    logic       Overrun;
    logic       Busy;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0, ov_cnt = 0, fe_long = 0, ov_long = 0;
    logic fe_prev = 1'b0, ov_prev = 1'b0;
    int fe0, ov0, lat, n, n2;
    logic [7:0] got [2];

    uart_receiver #(
        .CLK_FREQ  (50000000),
        .BAUD_RATE (115200),
        .TICK_DIV  (27)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Rxd        (Rxd),
        .RxData     (RxData),
        .RxValid    (RxValid),
        .RxAck      (RxAck),
        .FrameError (FrameError),
        .Overrun    (Overrun),
        .Busy       (Busy)
    );

    always #10 Clock = ~Clock;

    always @(negedge Clock) begin
        if (FrameError) fe_cnt++;
        if (Overrun) ov_cnt++;
        if (FrameError && fe_prev) fe_long++;
        if (Overrun && ov_prev) ov_long++;
        fe_prev = FrameError;
        ov_prev = Overrun;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        Rxd = 1'b0;
        repeat (BIT) @(negedge Clock);
        for (int i = 0; i < 8; i++) begin
            Rxd = b[i];
            repeat (BIT) @(negedge Clock);
        end
        Rxd = stop_bit;
        repeat (BIT) @(negedge Clock);
        Rxd = 1'b1;
    endtask

    task automatic pulse_ack();
        RxAck = 1'b1;
        @(negedge Clock);
        RxAck = 1'b0;
    endtask

    initial begin
        repeat (5) @(negedge Clock);
        chk("rst_data", {24'd0, RxData}, 32'h00);
        chk("rst_valid", {31'd0, RxValid}, 0);
        chk("rst_fe", {31'd0, FrameError}, 0);
        chk("rst_ov", {31'd0, Overrun}, 0);
        chk("rst_busy", {31'd0, Busy}, 0);
        Reset = 1'b0;
        repeat (20) @(negedge Clock);

        // single byte 0x55
        fe0 = fe_cnt; ov0 = ov_cnt; lat = 0;
        fork
            send_frame(8'h55, 1'b1);
            begin
                while (!RxValid && lat < 4400) begin
                    @(negedge Clock);
                    lat++;
                end
            end
        join
        chk("single_lat", {31'd0, (lat <= 4360)}, 1);
        chk("single_data", {24'd0, RxData}, 32'h55);
        chk("single_valid", {31'd0, RxValid}, 1);
        chk("single_fe_ov", fe_cnt + ov_cnt - fe0 - ov0, 0);
        pulse_ack();
        chk("single_ack", {31'd0, RxValid}, 0);
        repeat (100) @(negedge Clock);

        // back-to-back 0xA3, 0x0F with delayed ack
        fe0 = fe_cnt; ov0 = ov_cnt;
        got[0] = 8'h00; got[1] = 8'h00;
        fork
            begin
                send_frame(8'hA3, 1'b1);
                send_frame(8'h0F, 1'b1);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    n = 0;
                    while (!RxValid && n < 6000) begin
                        @(negedge Clock);
                        n++;
                    end
                    if (n >= 6000) chk("b2b_timeout", 0, 1);
                    got[k] = RxData;
                    repeat (4) @(negedge Clock);
                    pulse_ack();
                end
            end
        join
        chk("b2b_byte0", {24'd0, got[0]}, 32'hA3);
        chk("b2b_byte1", {24'd0, got[1]}, 32'h0F);
        chk("b2b_ov", ov_cnt - ov0, 0);
        chk("b2b_fe", fe_cnt - fe0, 0);
        repeat (100) @(negedge Clock);

        // overrun: 0x12 then 0x34, no ack
        ov0 = ov_cnt;
        send_frame(8'h12, 1'b1);
        chk("ovr_first", {24'd0, RxData}, 32'h12);
        send_frame(8'h34, 1'b1);
        chk("ovr_keep", {24'd0, RxData}, 32'h12);
        chk("ovr_valid", {31'd0, RxValid}, 1);
        chk("ovr_pulse", ov_cnt - ov0, 1);
        pulse_ack();
        chk("ovr_ack", {31'd0, RxValid}, 0);
        repeat (100) @(negedge Clock);

        // framing error: stop low, held low two further bits
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h7E, 1'b0);
        Rxd = 1'b0;
        repeat (2 * BIT) @(negedge Clock);
        chk("fe_pulse", fe_cnt - fe0, 1);
        chk("fe_busy", {31'd0, Busy}, 1);
        chk("fe_valid", {31'd0, RxValid}, 0);
        Rxd = 1'b1;
        repeat (6) @(negedge Clock);
        chk("fe_release", {31'd0, Busy}, 0);
        chk("fe_no_ov", ov_cnt - ov0, 0);
        repeat (50) @(negedge Clock);

        // false start: 100-clock glitch
        fe0 = fe_cnt; ov0 = ov_cnt; n = 0; n2 = 0;
        fork
            begin
                Rxd = 1'b0;
                repeat (100) @(negedge Clock);
                Rxd = 1'b1;
            end
            begin
                while (!Busy && n < 50) begin
                    @(negedge Clock);
                    n++;
                end
                n2 = n;
                while (Busy && n2 < 400) begin
                    @(negedge Clock);
                    n2++;
                end
            end
        join
        chk("glitch_seen", {31'd0, (n < 50)}, 1);
        chk("glitch_drop", {31'd0, (n2 <= 220)}, 1);
        chk("glitch_pulses", fe_cnt + ov_cnt - fe0 - ov0, 0);
        chk("glitch_valid", {31'd0, RxValid}, 0);
        repeat (100) @(negedge Clock);

        // reset at mid bit 4 of 0xF0 (bits 4..7 high keep line quiet after)
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (BIT * 5 + BIT / 2) @(negedge Clock);
                chk("rstmid_busy_before", {31'd0, Busy}, 1);
                Reset = 1'b1;
                @(negedge Clock);
                Reset = 1'b0;
                chk("rstmid_data", {24'd0, RxData}, 32'h00);
                chk("rstmid_valid", {31'd0, RxValid}, 0);
                chk("rstmid_busy", {31'd0, Busy}, 0);
            end
        join
        repeat (BIT) @(negedge Clock);
        chk("rstmid_no_load", {31'd0, RxValid}, 0);
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'hC9, 1'b1);
        chk("after_rst_data", {24'd0, RxData}, 32'hC9);
        chk("after_rst_valid", {31'd0, RxValid}, 1);
        repeat (100) @(negedge Clock);

        // ack on the exact load edge of 0x5A while 0xC9 still held
        ov0 = ov_cnt;
        fork
            send_frame(8'h5A, 1'b1);
            begin
                n = 0;
                while (!Busy && n < 1000) begin
                    @(negedge Clock);
                    n++;
                end
                while (Busy && n < 6000) begin
                    @(negedge Clock);
                    n++;
                end
                chk("sim_busy_seen", {31'd0, (n < 6000)}, 1);
                chk("sim_pre_data", {24'd0, RxData}, 32'hC9);
                pulse_ack();
                chk("sim_data", {24'd0, RxData}, 32'h5A);
                chk("sim_valid", {31'd0, RxValid}, 1);
            end
        join
        chk("sim_ov", ov_cnt - ov0, 0);
        chk("sim_hold", {31'd0, RxValid}, 1);
        pulse_ack();
        chk("sim_cleared", {31'd0, RxValid}, 0);

        chk("fe_one_cycle", fe_long, 0);
        chk("ov_one_cycle", ov_long, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
